infrarojo_filtro: RTL and testbench

INFRAROJO_FILTRO -- requirements
Module: infrarojo_filtro

---
 rtl/infrarojo_pkg.sv | 15 +
 rtl/sync_2ff.sv | 29 ++
 rtl/infrarojo_filtro.sv | 133 +++++++++++++
 tb/tb_infrarojo_filtro.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/infrarojo_pkg.sv
// rtl/infrarojo_pkg.sv - shared types and defaults for the IR sensor debounce filter
package infrarojo_pkg;

  localparam int DEB_CYCLES_DEF = 100000;
  localparam int COUNT_W_DEF    = 16;
  localparam int CNT_W          = 20;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    PEND_HI = 2'd1,
    ST_HI   = 2'd2,
    PEND_LO = 2'd3
  } filt_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/infrarojo_filtro.sv
// rtl/infrarojo_filtro.sv - debounced IR sensor level with edge strobes, event counter and sticky irq
module infrarojo_filtro
  import infrarojo_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int COUNT_W    = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ising,
  input  logic               enable,
  input  logic               clr,
  output logic               osing,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic [COUNT_W-1:0] count,
  output logic               irq
);

  // The entry into PEND_* already consumes one sample of the new level,
  // so the pending state finishes after DEB_CYCLES-1 further samples.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES > 1 ? DEB_CYCLES - 2 : 0);
  localparam bit               DEB_ONE  = (DEB_CYCLES == 1);

  logic s;

  filt_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               osing_q, osing_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               irq_q, irq_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ising),
    .q   (s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LO: begin
        if (s) begin
          cnt_d   = '0;
          state_d = DEB_ONE ? ST_HI : PEND_HI;
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = DEB_ONE ? ST_LO : PEND_LO;
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    osing_d = (state_d == ST_HI) || (state_d == PEND_LO);
    rise_d  = osing_d & ~osing_q;
    fall_d  = ~osing_d & osing_q;
  end

  // A counted rise wins over a simultaneous clear so the event is never lost.
  always_comb begin
    count_d = count_q;
    irq_d   = irq_q;
    if (clr) begin
      count_d = '0;
      irq_d   = 1'b0;
    end
    if (rise_q && enable) begin
      count_d = count_d + 1'b1;
      irq_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      osing_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      osing_q <= osing_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
      irq_q   <= irq_d;
    end
  end

  assign osing      = osing_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign count      = count_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_infrarojo_filtro.sv
// tb/tb_infrarojo_filtro.sv - randomized and directed checks of infrarojo_filtro against a run-length model
module tb_infrarojo_filtro;

  localparam int DEB = 4;
  localparam int CW  = 16;

  logic          clk;
  logic          rst;
  logic          ising;
  logic          enable;
  logic          clr;
  logic          osing;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] count;
  logic          irq;

  int total = 0;
  int bad   = 0;

  // Model: two-stage delay line, then a run length of samples disagreeing with the output level.
  logic          m_p1, m_s, m_osing, m_rise, m_fall, m_irq;
  logic [CW-1:0] m_count;
  int            m_run;

  infrarojo_filtro #(.DEB_CYCLES(DEB), .COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ising      (ising),
    .enable     (enable),
    .clr        (clr),
    .osing      (osing),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .count      (count),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_p1 = 0; m_s = 0; m_osing = 0; m_rise = 0; m_fall = 0;
    m_irq = 0; m_count = '0; m_run = 0;
  endtask

  task automatic step();
    logic r, f;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      r = 0; f = 0;
      if (clr) begin m_count = '0; m_irq = 0; end
      if (m_rise && enable) begin m_count = m_count + 1'b1; m_irq = 1; end
      if (m_s != m_osing) begin
        m_run = m_run + 1;
        if (m_run == DEB) begin
          m_osing = m_s; m_run = 0; r = m_s; f = !m_s;
        end
      end else begin
        m_run = 0;
      end
      m_rise = r; m_fall = f;
      m_s = m_p1; m_p1 = ising;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; ising = 0; enable = 0; clr = 0;
    model_reset();
    #2;
    total++; if (osing !== 1'b0) begin bad++; $display("FAIL reset_osing got=%b exp=0", osing); end
    total++; if (rise_pulse !== 1'b0) begin bad++; $display("FAIL reset_rise got=%b exp=0", rise_pulse); end
    total++; if (fall_pulse !== 1'b0) begin bad++; $display("FAIL reset_fall got=%b exp=0", fall_pulse); end
    total++; if (count !== 16'h0) begin bad++; $display("FAIL reset_count got=%h exp=0000", count); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    step(); step();
    rst = 0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_rise_latency();
    enable = 1;
    ising = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      total++; if (osing !== (i >= DEB + 2)) begin bad++; $display("FAIL rise_osing edge=%0d got=%b exp=%b", i, osing, i >= DEB + 2); end
      total++; if (rise_pulse !== (i == DEB + 2)) begin bad++; $display("FAIL rise_pulse edge=%0d got=%b exp=%b", i, rise_pulse, i == DEB + 2); end
    end
    total++; if (count !== 16'd1) begin bad++; $display("FAIL rise_count got=%h exp=0001", count); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rise_irq got=%b exp=1", irq); end
    ising = 0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_glitch();
    int pulses;
    clr = 1; step(); clr = 0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      ising = 1;
      for (int i = 0; i < DEB - 1; i++) begin
        step();
        if (osing !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) pulses++;
      end
      ising = 0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (osing !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) pulses++;
      end
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL glitch_activity got=%0d exp=0", pulses); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL glitch_count got=%h exp=0000", count); end
  endtask

  task automatic test_wrap();
    enable = 1;
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    m_count = 16'hFFFF;
    ising = 1;
    for (int i = 0; i < 10; i++) step();
    total++; if (count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h exp=0000", count); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL wrap_irq got=%b exp=1", irq); end
    ising = 0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_clr_coincident();
    int waited;
    enable = 1;
    force dut.count_q = 16'd7;
    #1;
    release dut.count_q;
    m_count = 16'd7;
    ising = 1;
    waited = 0;
    while (rise_pulse !== 1'b1 && waited < 20) begin step(); waited++; end
    total++; if (rise_pulse !== 1'b1) begin bad++; $display("FAIL clrc_timeout got=%b exp=1", rise_pulse); end
    clr = 1; step(); clr = 0;
    total++; if (count !== 16'd1) begin bad++; $display("FAIL clrc_count got=%h exp=0001", count); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL clrc_irq got=%b exp=1", irq); end
    clr = 1; step(); clr = 0;
    total++; if (count !== 16'd0) begin bad++; $display("FAIL clr_count got=%h exp=0000", count); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL clr_irq got=%b exp=0", irq); end
    ising = 0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_disabled();
    int rises, falls;
    enable = 0;
    rises = 0; falls = 0;
    for (int k = 0; k < 3; k++) begin
      ising = 1;
      for (int i = 0; i < 9; i++) begin step(); rises += rise_pulse; falls += fall_pulse; end
      ising = 0;
      for (int i = 0; i < 9; i++) begin step(); rises += rise_pulse; falls += fall_pulse; end
    end
    total++; if (rises !== 3) begin bad++; $display("FAIL dis_rises got=%0d exp=3", rises); end
    total++; if (falls !== 3) begin bad++; $display("FAIL dis_falls got=%0d exp=3", falls); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL dis_count got=%h exp=0000", count); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL dis_irq got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid_pend();
    int rises;
    enable = 1;
    ising = 1;
    for (int i = 0; i < 5; i++) step();
    rst = 1;
    #1;
    total++; if ({osing, rise_pulse, fall_pulse, irq} !== 4'b0 || count !== 16'd0) begin
      bad++; $display("FAIL midrst_async got=%b%b%b%b/%h exp=0000/0000", osing, rise_pulse, fall_pulse, irq, count);
    end
    step(); step();
    total++; if ({osing, rise_pulse, fall_pulse, irq} !== 4'b0 || count !== 16'd0) begin
      bad++; $display("FAIL midrst_held got=%b%b%b%b/%h exp=0000/0000", osing, rise_pulse, fall_pulse, irq, count);
    end
    rst = 0;
    rises = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      rises += rise_pulse;
      total++; if (osing !== (i >= DEB + 2)) begin bad++; $display("FAIL midrst_osing edge=%0d got=%b exp=%b", i, osing, i >= DEB + 2); end
    end
    total++; if (rises !== 1) begin bad++; $display("FAIL midrst_rises got=%0d exp=1", rises); end
    ising = 0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_random();
    int run_left;
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        ising = $urandom_range(0, 1);
        run_left = $urandom_range(1, 2 * DEB + 2);
      end
      run_left--;
      if ((c % 64) == 0) enable = $urandom_range(0, 1);
      clr = ($urandom_range(0, 15) == 0);
      step();
      total++; if (osing !== m_osing) begin bad++; $display("FAIL rnd_osing cyc=%0d got=%b exp=%b", c, osing, m_osing); end
      total++; if (rise_pulse !== m_rise) begin bad++; $display("FAIL rnd_rise cyc=%0d got=%b exp=%b", c, rise_pulse, m_rise); end
      total++; if (fall_pulse !== m_fall) begin bad++; $display("FAIL rnd_fall cyc=%0d got=%b exp=%b", c, fall_pulse, m_fall); end
      total++; if (count !== m_count) begin bad++; $display("FAIL rnd_count cyc=%0d got=%h exp=%h", c, count, m_count); end
      total++; if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", c, irq, m_irq); end
    end
    clr = 0;
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_wrap();
    test_clr_coincident();
    test_disabled();
    test_reset_mid_pend();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
